// File: rtl/bram_result_writer.sv
// bram_result_writer: copies a packed word vector into a single-port BRAM
// starting at BASE_ADDR, then reads every word back and compares it with the
// captured copy. It reports the index of the first word that read back wrong.
module bram_result_writer #(
    parameter int NUM_WORDS    = 8,
    parameter int W            = 8,
    parameter int ADDR_WIDTH   = 15,
    parameter int BASE_ADDR    = 16384,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NUM_WORDS*W-1:0]       data_in,
    output logic                         busy,
    output logic                         done,
    output logic                         verify_err,
    output logic [$clog2(NUM_WORDS)-1:0] err_index,
    output logic                         bram_en,
    output logic                         bram_ren,
    output logic                         bram_wen,
    output logic [ADDR_WIDTH-1:0]        bram_addr,
    output logic [W-1:0]                 bram_din,
    input  logic [W-1:0]                 bram_dout
);

    localparam int IW = $clog2(NUM_WORDS);
    // One extra bit so the counter can hold NUM_WORDS itself as the terminal value.
    localparam int CW = IW + 1;
    localparam logic [CW-1:0]         CNT_END  = CW'(NUM_WORDS);
    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [NUM_WORDS*W-1:0]  shadow_reg, shadow_next;
    logic                    en_reg, en_next;
    logic                    ren_reg, ren_next;
    logic                    wen_reg, wen_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [W-1:0]            din_reg, din_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    err_reg, err_next;
    logic [IW-1:0]           err_idx_reg, err_idx_next;

    // Outstanding-read tracker. Stage s is valid s+1 edges after its read was issued.
    logic [READ_LATENCY-1:0] vld_reg;
    logic [IW-1:0]           vidx_reg [READ_LATENCY];
    logic                    push_vld;
    logic [IW-1:0]           push_idx;

    // Shadow register viewed as an array of words.
    logic [W-1:0]            shadow_words [NUM_WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_words
            assign shadow_words[gi] = shadow_reg[gi*W +: W];
        end
    endgenerate

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign verify_err = err_reg;
    assign err_index  = err_idx_reg;
    assign bram_en    = en_reg;
    assign bram_ren   = ren_reg;
    assign bram_wen   = wen_reg;
    assign bram_addr  = addr_reg;
    assign bram_din   = din_reg;

    // Register the control state, the bus and the status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            shadow_reg  <= '0;
            en_reg      <= 1'b0;
            ren_reg     <= 1'b0;
            wen_reg     <= 1'b0;
            addr_reg    <= BASE;
            din_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shadow_reg  <= shadow_next;
            en_reg      <= en_next;
            ren_reg     <= ren_next;
            wen_reg     <= wen_next;
            addr_reg    <= addr_next;
            din_reg     <= din_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            err_idx_reg <= err_idx_next;
        end
    end

    // Shift the read tracker every cycle; new reads enter at stage 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                vidx_reg[s] <= '0;
            end
        end else begin
            for (int s = READ_LATENCY - 1; s > 0; s--) begin
                vld_reg[s]  <= vld_reg[s-1];
                vidx_reg[s] <= vidx_reg[s-1];
            end
            vld_reg[0]  <= push_vld;
            vidx_reg[0] <= push_idx;
        end
    end

    // Next-state logic: write sweep, read sweep, and readback compare.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shadow_next  = shadow_reg;
        en_next      = en_reg;
        ren_next     = ren_reg;
        wen_next     = wen_reg;
        addr_next    = addr_reg;
        din_next     = din_reg;
        busy_next    = busy_reg;
        done_next    = done_reg;
        err_next     = err_reg;
        err_idx_next = err_idx_reg;
        push_vld     = 1'b0;
        push_idx     = '0;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    // Capture the input and present write 0 on the same edge.
                    shadow_next  = data_in;
                    done_next    = 1'b0;
                    err_next     = 1'b0;
                    err_idx_next = '0;
                    busy_next    = 1'b1;
                    en_next      = 1'b1;
                    wen_next     = 1'b1;
                    ren_next     = 1'b0;
                    addr_next    = BASE;
                    din_next     = data_in[W-1:0];
                    cnt_next     = CW'(1);
                    state_next   = WRITE;
                end
            end

            WRITE: begin
                if (cnt_reg < CNT_END) begin
                    addr_next = BASE + ADDR_WIDTH'(cnt_reg);
                    din_next  = shadow_words[cnt_reg[IW-1:0]];
                    cnt_next  = cnt_reg + CW'(1);
                end else begin
                    // Writes finished: issue read 0 right away.
                    state_next = VERIFY;
                    wen_next   = 1'b0;
                    ren_next   = 1'b1;
                    addr_next  = BASE;
                    push_vld   = 1'b1;
                    push_idx   = '0;
                    cnt_next   = CW'(1);
                end
            end

            VERIFY: begin
                if (cnt_reg < CNT_END) begin
                    addr_next = BASE + ADDR_WIDTH'(cnt_reg);
                    push_vld  = 1'b1;
                    push_idx  = cnt_reg[IW-1:0];
                    cnt_next  = cnt_reg + CW'(1);
                end else begin
                    // All reads issued; keep the BRAM enabled for the last returns.
                    ren_next = 1'b0;
                end

                if (vld_reg[READ_LATENCY-1]) begin
                    if ((bram_dout != shadow_words[vidx_reg[READ_LATENCY-1]]) && !err_reg) begin
                        err_next     = 1'b1;
                        err_idx_next = vidx_reg[READ_LATENCY-1];
                    end
                    if (vidx_reg[READ_LATENCY-1] == LAST_IDX) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        en_next    = 1'b0;
                        ren_next   = 1'b0;
                        addr_next  = BASE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_result_writer.sv
// Testbench for bram_result_writer: runs a table of directed transactions, an
// asynchronous reset in the middle of a write, and randomized transactions.
// Each transaction is checked against a simple BRAM model and a reference model.
module tb_bram_result_writer;

    localparam int N      = 8;
    localparam int W      = 8;
    localparam int AW     = 15;
    localparam int BASE   = 16384;
    localparam int RL     = 2;
    localparam int DONE_K = 2*N + RL - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  start = 1'b0;
    logic [N*W-1:0]        data_in = '0;
    logic                  busy, done, verify_err;
    logic [$clog2(N)-1:0]  err_index;
    logic                  bram_en, bram_ren, bram_wen;
    logic [AW-1:0]         bram_addr;
    logic [W-1:0]          bram_din;
    logic [W-1:0]          bram_dout;

    int checks = 0;
    int errors = 0;

    bram_result_writer #(
        .NUM_WORDS(N), .W(W), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .verify_err(verify_err), .err_index(err_index),
        .bram_en(bram_en), .bram_ren(bram_ren), .bram_wen(bram_wen),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    // BRAM model: one output register, so data for a read issued at edge A is
    // valid after edge A+1 and sampled by the DUT at edge A+2.
    logic [W-1:0] mem [0:(1<<AW)-1];
    logic [W-1:0] rd_data = '0;
    bit           corrupt_en [N];
    int           rd_off;

    assign rd_off    = int'(bram_addr) - BASE;
    assign bram_dout = rd_data;

    always @(posedge clk) begin
        if (bram_en && bram_wen) mem[bram_addr] <= bram_din;
        if (bram_en && bram_ren) begin
            if (rd_off >= 0 && rd_off < N && corrupt_en[rd_off]) rd_data <= 8'hFF;
            else rd_data <= mem[bram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: expected status from the captured words and the corruption set.
    task automatic ref_model(input logic [N*W-1:0] data, input logic [N-1:0] cmask,
                             output bit exp_err, output int exp_idx);
        logic [W-1:0] w;
        logic [W-1:0] rb;
        exp_err = 1'b0;
        exp_idx = 0;
        for (int j = 0; j < N; j++) begin
            w  = data[j*W +: W];
            rb = cmask[j] ? 8'hFF : w;
            if (rb != w && !exp_err) begin
                exp_err = 1'b1;
                exp_idx = j;
            end
        end
    endtask

    task automatic run_txn(input string name, input logic [N*W-1:0] data, input logic [N-1:0] cmask,
                           input int restart_at, input int change_at,
                           input bit exp_err, input int exp_idx);
        int wr_bad, rd_bad, busy_bad, nwr, nrd, done_k, mem_bad;
        logic [W-1:0] w;
        wr_bad = 0; rd_bad = 0; busy_bad = 0; nwr = 0; nrd = 0; done_k = -1; mem_bad = 0;
        for (int i = 0; i < N; i++) corrupt_en[i] = cmask[i];

        @(negedge clk);
        data_in = data;
        start   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                start = 1'b0;
                check({name, " start_clear"}, {busy, done, verify_err, 29'(err_index)}, {1'b1, 1'b0, 1'b0, 29'd0});
            end
            if (change_at > 0 && k == change_at - 1) data_in = {N{8'hAA}};
            if (restart_at > 0 && k == restart_at - 1) start = 1'b1;
            if (restart_at > 0 && k == restart_at) start = 1'b0;

            if (busy !== (k < DONE_K)) busy_bad++;
            if (k < DONE_K && bram_en !== 1'b1) busy_bad++;
            if (bram_en && bram_wen) begin
                nwr++;
                w = data[(k % N)*W +: W];
                if (!(k < N && int'(bram_addr) == BASE + k && bram_din == w && !bram_ren)) wr_bad++;
            end
            if (bram_en && bram_ren) begin
                nrd++;
                if (!(k >= N && k < 2*N && int'(bram_addr) == BASE + (k - N) && !bram_wen)) rd_bad++;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;

        check({name, " writes"}, {32'(nwr), 32'(wr_bad)}, {32'(N), 32'd0});
        check({name, " reads"}, {32'(nrd), 32'(rd_bad)}, {32'(N), 32'd0});
        check({name, " busy_en"}, 64'(busy_bad), 64'd0);
        check({name, " done_cycle"}, 64'(done_k), 64'(DONE_K));
        check({name, " done_bus"}, {bram_en, bram_ren, bram_wen, 32'(bram_addr)}, {3'b000, 32'(BASE)});
        check({name, " verify_err"}, 64'(verify_err), 64'(exp_err));
        check({name, " err_index"}, 64'(err_index), 64'(exp_idx));
        for (int i = 0; i < N; i++) begin
            w = data[i*W +: W];
            if (mem[BASE + i] !== w) mem_bad++;
        end
        check({name, " mem_image"}, 64'(mem_bad), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check({name, " done_hold"}, {done, busy, verify_err}, {1'b1, 1'b0, exp_err});
        $display("txn %s data=%h cmask=%b err=%0d idx=%0d done_k=%0d",
                 name, data, cmask, verify_err, err_index, done_k);
    endtask

    typedef struct {
        string          name;
        logic [N*W-1:0] data;
        logic [N-1:0]   cmask;
        int             restart_at;
        int             change_at;
        bit             exp_err;
        int             exp_idx;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [N*W-1:0] rdata;
        logic [N-1:0]   rmask;
        int             rr, rc, ridx;
        bit             rerr;

        vecs[0] = '{"basic",          64'h1716151413121110, 8'h00, 0, 0, 1'b0, 0};
        vecs[1] = '{"corrupt5_7",     64'h1716151413121110, 8'hA0, 0, 0, 1'b1, 5};
        vecs[2] = '{"restart_ignored",64'h1716151413121110, 8'h00, 4, 0, 1'b0, 0};
        vecs[3] = '{"data_change",    64'h1716151413121110, 8'h00, 0, 1, 1'b0, 0};
        vecs[4] = '{"corrupt_first",  64'h0123456789ABCDEF, 8'h01, 0, 0, 1'b1, 0};
        vecs[5] = '{"corrupt_last",   64'h0011223344556677, 8'h80, 0, 0, 1'b1, 7};
        vecs[6] = '{"corrupt_ff_word",64'h00000000FF000000, 8'h08, 0, 0, 1'b0, 0};

        // Power-on reset and reset-state check.
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              {busy, done, verify_err, 29'(err_index), bram_en, bram_ren, bram_wen, 15'(bram_addr), 8'(bram_din)},
              {1'b0, 1'b0, 1'b0, 29'd0, 1'b0, 1'b0, 1'b0, 15'(BASE), 8'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            run_txn(vecs[v].name, vecs[v].data, vecs[v].cmask, vecs[v].restart_at,
                    vecs[v].change_at, vecs[v].exp_err, vecs[v].exp_idx);
        end

        // Asynchronous reset in the middle of the write sweep.
        @(negedge clk);
        data_in = vecs[0].data;
        start   = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midwrite_active", {busy, bram_wen, bram_en}, {1'b1, 1'b1, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset",
              {busy, done, verify_err, 29'(err_index), bram_en, bram_ren, bram_wen, 15'(bram_addr), 8'(bram_din)},
              {1'b0, 1'b0, 1'b0, 29'd0, 1'b0, 1'b0, 1'b0, 15'(BASE), 8'd0});
        $display("txn async_reset busy=%0d wen=%0d addr=%0d", busy, bram_wen, bram_addr);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            if (v == 1 || v == 2 || v == 3) continue;
            run_txn(vecs[v].name, vecs[v].data, vecs[v].cmask, vecs[v].restart_at,
                    vecs[v].change_at, vecs[v].exp_err, vecs[v].exp_idx);
        end

        // Randomized transactions checked against the reference model.
        for (int t = 0; t < 8; t++) begin
            rdata = {$urandom, $urandom};
            rmask = 8'($urandom & $urandom);
            rr    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 16)) : 0;
            rc    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : 0;
            ref_model(rdata, rmask, rerr, ridx);
            run_txn($sformatf("rand%0d", t), rdata, rmask, rr, rc, rerr, ridx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
